// File: rtl/calendar_pkg.sv
// Shared constants for the calendar stage: BCD months, days-in-month values,
// day-of-week encoding and the default reset date (2000-01-01, a Saturday).
package calendar_pkg;

   localparam logic [7:0] JAN = 8'h01;
   localparam logic [7:0] FEB = 8'h02;
   localparam logic [7:0] MAR = 8'h03;
   localparam logic [7:0] APR = 8'h04;
   localparam logic [7:0] MAY = 8'h05;
   localparam logic [7:0] JUN = 8'h06;
   localparam logic [7:0] JUL = 8'h07;
   localparam logic [7:0] AUG = 8'h08;
   localparam logic [7:0] SEP = 8'h09;
   localparam logic [7:0] OCT = 8'h10;
   localparam logic [7:0] NOV = 8'h11;
   localparam logic [7:0] DEC = 8'h12;

   localparam logic [7:0] DIM_28 = 8'h28;
   localparam logic [7:0] DIM_29 = 8'h29;
   localparam logic [7:0] DIM_30 = 8'h30;
   localparam logic [7:0] DIM_31 = 8'h31;

   typedef enum logic [2:0] {
      SUN = 3'd0,
      MON = 3'd1,
      TUE = 3'd2,
      WED = 3'd3,
      THU = 3'd4,
      FRI = 3'd5,
      SAT = 3'd6
   } dow_e;

   localparam logic [7:0] DEF_DAY   = 8'h01;
   localparam logic [7:0] DEF_MONTH = JAN;
   localparam logic [7:0] DEF_YEAR  = 8'h00;
   localparam logic [2:0] DEF_DOW   = 3'(SAT);

endpackage

// File: rtl/calendar_days_in_month.sv
// Combinational days-in-month lookup: BCD month plus leap flag -> BCD day count.
module days_in_month
   import calendar_pkg::*;
(
   input  logic [7:0] month,
   input  logic       leap,
   output logic [7:0] dim
);

   // Month-length table; February depends on the leap flag.
   always_comb begin
      dim = DIM_31;
      case (month)
         JAN, MAR, MAY, JUL, AUG, OCT, DEC: dim = DIM_31;
         APR, JUN, SEP, NOV:                dim = DIM_30;
         FEB:                               dim = leap ? DIM_29 : DIM_28;
         default:                           dim = DIM_31;
      endcase
   end

endmodule

// File: rtl/calendar.sv
// Date keeper (day/month/year in packed BCD) driven by end_of_day and manual-set pulses.
// Optional day-of-week counter and dow port are enabled by defining CALENDAR_DOW_EN.
module calendar
   import calendar_pkg::*;
#(
   parameter logic [7:0] RESET_DAY   = DEF_DAY,
   parameter logic [7:0] RESET_MONTH = DEF_MONTH,
   parameter logic [7:0] RESET_YEAR  = DEF_YEAR,
   parameter logic [2:0] RESET_DOW   = DEF_DOW
)
(
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       end_of_day,
   input  logic       inc_day,
   input  logic       inc_month,
   input  logic       inc_year,
   output logic [7:0] day,
   output logic [7:0] month,
   output logic [7:0] year,
   output logic       end_of_year
`ifdef CALENDAR_DOW_EN
   ,
   output logic [2:0] dow
`endif
);

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] res;
      if (v[3:0] == 4'h9) begin
         res = {v[7:4] + 4'h1, 4'h0};
      end else begin
         res = {v[7:4], v[3:0] + 4'h1};
      end
      return res;
   endfunction

   // 20xx is leap when xx is a multiple of 4, decided from the BCD digits directly.
   function automatic logic is_leap(input logic [7:0] y);
      logic res;
      if (y[4]) begin
         res = (y[3:0] == 4'h2) || (y[3:0] == 4'h6);
      end else begin
         res = (y[3:0] == 4'h0) || (y[3:0] == 4'h4) || (y[3:0] == 4'h8);
      end
      return res;
   endfunction

   logic [7:0] r_day;
   logic [7:0] r_month;
   logic [7:0] r_year;
   logic       r_end_of_year;

   logic [7:0] w_day_d;
   logic [7:0] w_month_d;
   logic [7:0] w_year_d;
   logic       w_eoy_d;

   logic [7:0] w_month_inc;
   logic [7:0] w_year_inc;
   logic [7:0] w_nxt_month;
   logic [7:0] w_nxt_year;
   logic [7:0] w_dim_cur;
   logic [7:0] w_dim_nxt;
   logic [7:0] w_day_clamp;

   assign w_month_inc = (r_month == DEC) ? JAN : bcd_inc(r_month);
   assign w_year_inc  = (r_year == 8'h99) ? 8'h00 : bcd_inc(r_year);

   // The clamp must see the month/year the manual set is about to produce.
   assign w_nxt_year  = inc_year ? w_year_inc : r_year;
   assign w_nxt_month = (!inc_year && inc_month) ? w_month_inc : r_month;
   assign w_day_clamp = (r_day > w_dim_nxt) ? w_dim_nxt : r_day;

   days_in_month u_dim_cur (
      .month (r_month),
      .leap  (is_leap(r_year)),
      .dim   (w_dim_cur)
   );

   days_in_month u_dim_nxt (
      .month (w_nxt_month),
      .leap  (is_leap(w_nxt_year)),
      .dim   (w_dim_nxt)
   );

   // Next-date selection: one event per cycle, inc_year highest, end_of_day lowest.
   always_comb begin
      w_day_d   = r_day;
      w_month_d = r_month;
      w_year_d  = r_year;
      w_eoy_d   = 1'b0;
      if (inc_year) begin
         w_year_d = w_year_inc;
         w_day_d  = w_day_clamp;
      end else if (inc_month) begin
         w_month_d = w_month_inc;
         w_day_d   = w_day_clamp;
      end else if (inc_day) begin
         w_day_d = (r_day >= w_dim_cur) ? 8'h01 : bcd_inc(r_day);
      end else if (end_of_day) begin
         if (r_day < w_dim_cur) begin
            w_day_d = bcd_inc(r_day);
         end else begin
            w_day_d   = 8'h01;
            w_month_d = w_month_inc;
            if (r_month == DEC) begin
               w_year_d = w_year_inc;
               w_eoy_d  = 1'b1;
            end else begin
               w_year_d = r_year;
            end
         end
      end else begin
         w_day_d = r_day;
      end
   end

   // Date and rollover-pulse registers.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         r_day         <= RESET_DAY;
         r_month       <= RESET_MONTH;
         r_year        <= RESET_YEAR;
         r_end_of_year <= 1'b0;
      end else begin
         r_day         <= w_day_d;
         r_month       <= w_month_d;
         r_year        <= w_year_d;
         r_end_of_year <= w_eoy_d;
      end
   end

   assign day         = r_day;
   assign month       = r_month;
   assign year        = r_year;
   assign end_of_year = r_end_of_year;

`ifdef CALENDAR_DOW_EN
   logic [2:0] r_dow;
   logic       w_dow_adv;

   assign w_dow_adv = !inc_year && !inc_month && (inc_day || end_of_day);

   // Day-of-week counter, mod 7, advanced only by day-stepping events.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         r_dow <= RESET_DOW;
      end else if (w_dow_adv) begin
         r_dow <= (r_dow == 3'd6) ? 3'd0 : r_dow + 3'd1;
      end else begin
         r_dow <= r_dow;
      end
   end

   assign dow = r_dow;
`endif

endmodule

// File: tb/tb_calendar.sv
// Scoreboard bench for calendar: integer-date reference model, directed
// test-plan sequences followed by randomized event traffic.
module tb_calendar;

   logic       clk_100MHz = 1'b0;
   logic       reset      = 1'b0;
   logic       end_of_day = 1'b0;
   logic       inc_day    = 1'b0;
   logic       inc_month  = 1'b0;
   logic       inc_year   = 1'b0;
   logic [7:0] day;
   logic [7:0] month;
   logic [7:0] year;
   logic       end_of_year;
`ifdef CALENDAR_DOW_EN
   logic [2:0] dow;
`endif

   calendar dut (
      .clk_100MHz  (clk_100MHz),
      .reset       (reset),
      .end_of_day  (end_of_day),
      .inc_day     (inc_day),
      .inc_month   (inc_month),
      .inc_year    (inc_year),
      .day         (day),
      .month       (month),
      .year        (year),
      .end_of_year (end_of_year)
`ifdef CALENDAR_DOW_EN
      ,
      .dow         (dow)
`endif
   );

   always #5 clk_100MHz = ~clk_100MHz;

   typedef struct packed {
      logic [7:0] d;
      logic [7:0] m;
      logic [7:0] y;
      logic       eoy;
      logic [2:0] w;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model: plain integers, calendar rules, BCD only at the output.
   int m_d = 1, m_m = 1, m_y = 0, m_w = 6;
   bit m_eoy = 1'b0;

   function automatic int dim(input int mm, input int yy);
      if (mm == 2) return (yy % 4 == 0) ? 29 : 28;
      else if (mm == 4 || mm == 6 || mm == 9 || mm == 11) return 30;
      else return 31;
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) * 16) + (v % 10));
   endfunction

   task automatic model_step(input bit r, input bit iy, input bit im, input bit id, input bit eod);
      m_eoy = 1'b0;
      if (r) begin
         m_d = 1; m_m = 1; m_y = 0; m_w = 6;
      end else if (iy) begin
         m_y = (m_y + 1) % 100;
         if (m_d > dim(m_m, m_y)) m_d = dim(m_m, m_y);
      end else if (im) begin
         m_m = (m_m % 12) + 1;
         if (m_d > dim(m_m, m_y)) m_d = dim(m_m, m_y);
      end else if (id) begin
         m_d = (m_d >= dim(m_m, m_y)) ? 1 : m_d + 1;
         m_w = (m_w + 1) % 7;
      end else if (eod) begin
         m_w = (m_w + 1) % 7;
         if (m_d < dim(m_m, m_y)) begin
            m_d = m_d + 1;
         end else begin
            m_d = 1;
            if (m_m == 12) begin
               m_m = 1;
               m_y = (m_y + 1) % 100;
               m_eoy = 1'b1;
            end else begin
               m_m = m_m + 1;
            end
         end
      end
   endtask

   // Drive one cycle of inputs and queue the response expected after the next edge.
   task automatic step(input bit r, input bit iy, input bit im, input bit id, input bit eod);
      exp_t e;
      @(negedge clk_100MHz);
      reset = r; inc_year = iy; inc_month = im; inc_day = id; end_of_day = eod;
      model_step(r, iy, im, id, eod);
      e.d = to_bcd(m_d); e.m = to_bcd(m_m); e.y = to_bcd(m_y);
      e.eoy = m_eoy; e.w = 3'(m_w);
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic set_date(input int dd, input int mm, input int yy);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < yy; i++) step(0, 1, 0, 0, 0);
      for (int i = 1; i < mm; i++) step(0, 0, 1, 0, 0);
      for (int i = 1; i < dd; i++) step(0, 0, 0, 1, 0);
   endtask

   // Monitor: every cycle the DUT presents a new date; compare it with the queued expectation.
   always @(posedge clk_100MHz) begin
      exp_t e;
      bit   ok;
      #1;
      if (exp_q.size() != 0) begin
         e  = exp_q.pop_front();
         ok = (day == e.d) && (month == e.m) && (year == e.y) && (end_of_year == e.eoy);
`ifdef CALENDAR_DOW_EN
         ok = ok && (dow == e.w);
`endif
         n_checks++;
         if (ok) begin
            n_pass++;
         end else begin
`ifdef CALENDAR_DOW_EN
            $display("FAIL date @%0t: got %h/%h/%h eoy=%b dow=%0d, expected %h/%h/%h eoy=%b dow=%0d",
                     $time, day, month, year, end_of_year, dow, e.d, e.m, e.y, e.eoy, e.w);
`else
            $display("FAIL date @%0t: got %h/%h/%h eoy=%b, expected %h/%h/%h eoy=%b",
                     $time, day, month, year, end_of_year, e.d, e.m, e.y, e.eoy);
`endif
         end
      end
   end

   initial begin
      int guard;
      bit r, iy, im, id, eod;

      // Reset held, then quiet outputs.
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
      idle(5);

      // 31 end_of_day pulses: day-of-week back to Saturday after 7, Feb 1 after 31.
      for (int i = 0; i < 31; i++) step(0, 0, 0, 0, 1);
      idle(2);

      // February in a leap and a non-leap year.
      set_date(28, 2, 0); step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1); idle(1);
      set_date(28, 2, 1); step(0, 0, 0, 0, 1); idle(1);

      // Year rollover pulse and its absence one day earlier.
      set_date(31, 12, 99); step(0, 0, 0, 0, 1); idle(3);
      set_date(30, 12, 99); step(0, 0, 0, 0, 1); idle(2);

      // Clamp on manual month/year sets.
      set_date(31, 1, 0); step(0, 0, 1, 0, 0); step(0, 1, 0, 0, 0); idle(1);
      set_date(31, 3, 1); step(0, 0, 1, 0, 0); idle(1);

      // Priority: inc_day beats end_of_day; reset beats everything.
      set_date(30, 4, 0); step(0, 0, 0, 1, 1); idle(1);
      step(0, 1, 1, 1, 1);
      step(1, 1, 0, 0, 0); idle(2);

      // Random traffic, mostly end_of_day with sparse manual sets and rare resets.
      for (int i = 0; i < 4000; i++) begin
         r   = ($urandom_range(0, 299) == 0);
         iy  = ($urandom_range(0, 19) == 0);
         im  = ($urandom_range(0, 9) == 0);
         id  = ($urandom_range(0, 7) == 0);
         eod = ($urandom_range(0, 2) != 0);
         step(r, iy, im, id, eod);
      end
      idle(2);

      guard = 0;
      while (exp_q.size() != 0 && guard < 10) begin
         @(posedge clk_100MHz);
         guard++;
      end
      #2;
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
